// File: rtl/proc_control_fsm_pkg.sv
// Shared definitions for the simple-processor control sequencer: timestep encoding,
// opcode constants and instruction-word field extraction.
package proc_control_fsm_pkg;

  localparam int unsigned OpcW  = 3;
  localparam int unsigned RegW  = 3;
  localparam int unsigned NRegs = 2 ** RegW;
  localparam int unsigned IrW   = OpcW + 2 * RegW;

  localparam logic [OpcW-1:0] OpMv  = 3'b000;
  localparam logic [OpcW-1:0] OpMvi = 3'b001;
  localparam logic [OpcW-1:0] OpAdd = 3'b010;
  localparam logic [OpcW-1:0] OpSub = 3'b011;

  typedef enum logic [1:0] {
    StT0 = 2'd0,
    StT1 = 2'd1,
    StT2 = 2'd2,
    StT3 = 2'd3
  } tstep_e;

  // Instruction word layout: III_XXX_YYY
  function automatic logic [OpcW-1:0] ir_opc(input logic [IrW-1:0] ir);
    return ir[IrW-1 -: OpcW];
  endfunction

  function automatic logic [RegW-1:0] ir_x(input logic [IrW-1:0] ir);
    return ir[2*RegW-1 -: RegW];
  endfunction

  function automatic logic [RegW-1:0] ir_y(input logic [IrW-1:0] ir);
    return ir[RegW-1:0];
  endfunction

endpackage

// File: rtl/proc_control_fsm_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module proc_control_fsm_dec3to8
  import proc_control_fsm_pkg::*;
(
  input  logic [RegW-1:0]  sel,
  input  logic             en,
  output logic [NRegs-1:0] dec
);

  always_comb begin
    dec = '0;
    if (en) dec[sel] = 1'b1;
  end

endmodule

// File: rtl/proc_control_fsm.sv
// Control sequencer for the 9-bit simple processor: steps T0..T3 per instruction and
// decodes the IR into bus-select, register-load, ALU and done strobes.
module proc_control_fsm
  import proc_control_fsm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [IrW-1:0]   ir,
  output logic             ir_we,
  output logic [NRegs-1:0] r_in,
  output logic [NRegs-1:0] r_out,
  output logic             din_out,
  output logic             g_out,
  output logic             a_in,
  output logic             g_in,
  output logic             add_sub,
  output logic             done,
  output logic [1:0]       tstep
);

  tstep_e state_q, state_d;
  logic [NRegs-1:0] x_oh, y_oh;

  // Decoders are gated by reset so every register strobe is forced low while rst is high.
  proc_control_fsm_dec3to8 u_dec_x (
    .sel (ir_x(ir)),
    .en  (~rst),
    .dec (x_oh)
  );

  proc_control_fsm_dec3to8 u_dec_y (
    .sel (ir_y(ir)),
    .en  (~rst),
    .dec (y_oh)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= StT0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ir_we   = 1'b0;
    r_in    = '0;
    r_out   = '0;
    din_out = 1'b0;
    g_out   = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    add_sub = 1'b0;
    done    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StT0: begin
          ir_we = run;
          if (run) state_d = StT1;
        end
        StT1: begin
          case (ir_opc(ir))
            OpMv: begin
              r_out   = y_oh;
              r_in    = x_oh;
              done    = 1'b1;
              state_d = StT0;
            end
            OpMvi: begin
              din_out = 1'b1;
              r_in    = x_oh;
              done    = 1'b1;
              state_d = StT0;
            end
            OpAdd, OpSub: begin
              r_out   = x_oh;
              a_in    = 1'b1;
              state_d = StT2;
            end
            default: begin
              done    = 1'b1;
              state_d = StT0;
            end
          endcase
        end
        StT2: begin
          r_out   = y_oh;
          g_in    = 1'b1;
          add_sub = ir[OpcW*2];
          state_d = StT3;
        end
        StT3: begin
          g_out   = 1'b1;
          r_in    = x_oh;
          done    = 1'b1;
          state_d = StT0;
        end
      endcase
    end
  end

  assign tstep = state_q;

endmodule
